// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a byte FIFO with a valid/ready read port.
// Framing errors and overruns are reported as single-cycle pulses.
module uart_rx_fifo #(
  parameter int CLOCK_HZ   = 1_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          Rx_i,
  output logic [7:0]                    Data_o,
  output logic                          Valid_o,
  input  logic                          Ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   Count_o,
  output logic                          Busy_o,
  output logic                          FramingError_o,
  output logic                          Overrun_o
);

  localparam int CPB = CLOCK_HZ / BAUD;
  localparam int TW  = $clog2(CPB);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CPB - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(CPB / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  logic          meta_q;
  logic          rx_s_q;
  state_t        state_q;
  logic [TW-1:0] tick_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          busy_q;
  logic          fe_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q;
  logic          ov_q;

  logic          push_req_s;
  logic          pop_s;
  logic          full_s;
  logic          push_ok_s;
  logic          ovr_s;
  logic [PW-1:0] rd_next_s;

  // Two-flop synchroniser; the line idles high so the flops reset to 1.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      meta_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      meta_q <= Rx_i;
      rx_s_q <= meta_q;
    end
  end

  // Receiver FSM with registered Busy_o and FramingError_o.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      busy_q  <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      fe_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tick_q <= '0;
          if (!rx_s_q) begin
            state_q <= S_START;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        S_START: begin
          if (tick_q == TICK_MID) begin
            tick_q <= '0;
            bit_q  <= 3'd0;
            if (rx_s_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DATA;
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        S_DATA: begin
          if (tick_q == TICK_LAST) begin
            tick_q  <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        S_STOP: begin
          if (tick_q == TICK_LAST) begin
            tick_q <= '0;
            if (rx_s_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              fe_q    <= 1'b1;
              state_q <= S_WAIT_HIGH;
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        S_WAIT_HIGH: begin
          // A break keeps us here, so it reports only one framing error.
          if (rx_s_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_WAIT_HIGH;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tick_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign push_req_s = (state_q == S_STOP) && (tick_q == TICK_LAST) && rx_s_q;
  assign pop_s      = valid_q & Ready_i;
  assign full_s     = (count_q == CW'(FIFO_DEPTH));
  assign push_ok_s  = push_req_s & (~full_s | pop_s);
  assign ovr_s      = push_req_s & full_s & ~pop_s;
  assign rd_next_s  = rd_q + PW'(1);

  // FIFO next-state, including the registered head byte with write bypass.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    data_d  = data_q;
    if (push_ok_s) begin
      wr_d = wr_q + PW'(1);
    end else begin
      wr_d = wr_q;
    end
    if (pop_s) begin
      rd_d = rd_next_s;
    end else begin
      rd_d = rd_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (pop_s) begin
      if (count_q == CW'(1)) begin
        if (push_ok_s) begin
          data_d = shift_q;
        end else begin
          data_d = data_q;
        end
      end else begin
        data_d = mem_q[rd_next_s];
      end
    end else begin
      if ((count_q == CW'(0)) && push_ok_s) begin
        data_d = shift_q;
      end else begin
        data_d = data_q;
      end
    end
  end

  // FIFO storage, pointers and registered status outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_q] <= shift_q;
      end
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      data_q  <= data_d;
      valid_q <= (count_d != CW'(0));
      ov_q    <= ovr_s;
    end
  end

  assign Data_o         = data_q;
  assign Valid_o        = valid_q;
  assign Count_o        = count_q;
  assign Busy_o         = busy_q;
  assign FramingError_o = fe_q;
  assign Overrun_o      = ov_q;

endmodule
